// File: rtl/gam_winner_search_if.sv
// gam_winner_search_if -- bundle of all non-clock signals of the GAM winner
// search engine: scan control, results and the node-memory read port.
//   slave  modport : engine side (gam_winner_search)
//   master modport : layer controller + node weight memory side
// Parameters mirror gam_winner_search; derived widths follow the same rules.
interface gam_winner_search_if #(
   parameter int DIM       = 4,
   parameter int LANES     = 2,
   parameter int WIDTH     = 8,
   parameter int MAX_NODES = 8
);
   localparam int B      = DIM / LANES;
   localparam int DIST_W = 2*WIDTH + 2 + $clog2(DIM);
   localparam int NODE_W = $clog2(MAX_NODES);
   localparam int CNT_W  = $clog2(MAX_NODES + 1);
   localparam int BEAT_W = (B > 1) ? $clog2(B) : 1;

   // scan control
   logic                   start;
   logic [DIM*WIDTH-1:0]   x_vec;
   logic [CNT_W-1:0]       num_nodes;
   logic [DIST_W-1:0]      thresh;
   logic                   busy;
   logic                   done;
   // node memory read port
   logic                   rd_en;
   logic [NODE_W-1:0]      rd_node;
   logic [BEAT_W-1:0]      rd_beat;
   logic [LANES*WIDTH-1:0] rd_data;
   // results
   logic                   min1_valid;
   logic                   min2_valid;
   logic [NODE_W-1:0]      min1_node;
   logic [NODE_W-1:0]      min2_node;
   logic [DIST_W-1:0]      min1_dist;
   logic [DIST_W-1:0]      min2_dist;
   logic                   novel;

   modport slave (
      input  start, x_vec, num_nodes, thresh, rd_data,
      output busy, done, rd_en, rd_node, rd_beat,
             min1_valid, min2_valid, min1_node, min2_node,
             min1_dist, min2_dist, novel
   );

   modport master (
      output start, x_vec, num_nodes, thresh, rd_data,
      input  busy, done, rd_en, rd_node, rd_beat,
             min1_valid, min2_valid, min1_node, min2_node,
             min1_dist, min2_dist, novel
   );
endinterface

// File: rtl/gam_winner_search.sv
// gam_winner_search -- scans num_nodes weight vectors from node memory,
// computes squared Euclidean distance to the latched x_vec and keeps the two
// nearest nodes (strict less-than: lower node index wins ties).
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : gam_winner_search_if.slave
//                start/x_vec/num_nodes/thresh in, busy/done out,
//                rd_en/rd_node/rd_beat out, rd_data in (1-cycle latency),
//                min1_*/min2_* results, novel flag.
// Optional feature: define GAM_WINNER_THRESH_EN to latch thresh and drive
// novel = !min1_valid || min1_dist > thresh; otherwise novel is tied to 0.
module gam_winner_search #(
   parameter int DIM       = 4,
   parameter int LANES     = 2,
   parameter int WIDTH     = 8,
   parameter int MAX_NODES = 8
) (
   input logic                clk,
   input logic                rst_n,
   gam_winner_search_if.slave bus
);
   localparam int B      = DIM / LANES;
   localparam int DIST_W = 2*WIDTH + 2 + $clog2(DIM);
   localparam int NODE_W = $clog2(MAX_NODES);
   localparam int CNT_W  = $clog2(MAX_NODES + 1);
   localparam int BEAT_W = (B > 1) ? $clog2(B) : 1;
   localparam int SQ_W   = 2*(WIDTH + 1);

   localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(B - 1);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_ISSUE = 2'd1;
   localparam logic [1:0] S_DRAIN = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;

   logic [1:0]           state_q, state_d;
   logic [DIM*WIDTH-1:0] x_q, x_d;
   logic [CNT_W-1:0]     n_q, n_d;
   logic [NODE_W-1:0]    node_q, node_d;
   logic [BEAT_W-1:0]    beat_q, beat_d;

   // pipeline metadata: p1 travels with rd_data, p2 with the registered diffs
   logic                 p1_valid_q, p1_first_q, p1_last_q;
   logic [NODE_W-1:0]    p1_node_q;
   logic [BEAT_W-1:0]    p1_beat_q;
   logic                 p2_valid_q, p2_first_q, p2_last_q;
   logic [NODE_W-1:0]    p2_node_q;
   logic signed [WIDTH:0] diff_q [LANES];
   logic signed [WIDTH:0] diff_d [LANES];

   logic [DIST_W-1:0]    acc_q, acc_d, sq_sum;
   logic                 min1_valid_q, min1_valid_d, min2_valid_q, min2_valid_d;
   logic [NODE_W-1:0]    min1_node_q, min1_node_d, min2_node_q, min2_node_d;
   logic [DIST_W-1:0]    min1_dist_q, min1_dist_d, min2_dist_q, min2_dist_d;

   logic                 accept, node_last, final_update;
   logic [CNT_W-1:0]     n_last;

   assign accept       = (state_q == S_IDLE) && bus.start;
   assign n_last       = n_q - CNT_W'(1);
   assign node_last    = (CNT_W'(node_q) == n_last);
   // last beat of the last node reaching the two-min update
   assign final_update = p2_valid_q && p2_last_q && (CNT_W'(p2_node_q) == n_last);

   // ---------------- control FSM and read address generation ----------------
   always_comb begin
      state_d = state_q;
      x_d     = x_q;
      n_d     = n_q;
      node_d  = node_q;
      beat_d  = beat_q;
      case (state_q)
         S_IDLE: begin
            if (bus.start) begin
               x_d     = bus.x_vec;
               n_d     = bus.num_nodes;
               state_d = (bus.num_nodes == '0) ? S_DONE : S_ISSUE;
            end
         end
         S_ISSUE: begin
            if (beat_q == BEAT_LAST) begin
               beat_d = '0;
               if (node_last) begin
                  node_d  = '0;
                  state_d = S_DRAIN;
               end else begin
                  node_d = node_q + NODE_W'(1);
               end
            end else begin
               beat_d = beat_q + BEAT_W'(1);
            end
         end
         S_DRAIN: begin
            if (final_update) state_d = S_DONE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // ---------------- stage 1: per-lane signed differences ----------------
   always_comb begin
      for (int unsigned l = 0; l < LANES; l++) begin
         logic signed [WIDTH-1:0] rd_l, x_l;
         rd_l      = bus.rd_data[l*WIDTH +: WIDTH];
         x_l       = x_q[(int'(p1_beat_q)*LANES + int'(l))*WIDTH +: WIDTH];
         diff_d[l] = {rd_l[WIDTH-1], rd_l} - {x_l[WIDTH-1], x_l};
      end
   end

   // ---------------- stage 2: square, accumulate, two-min update ----------------
   always_comb begin
      sq_sum = '0;
      for (int unsigned l = 0; l < LANES; l++) begin
         logic signed [SQ_W-1:0] sq;
         sq     = diff_q[l] * diff_q[l];
         sq_sum = sq_sum + DIST_W'(sq);
      end

      acc_d = acc_q;
      if (p2_valid_q) acc_d = p2_first_q ? sq_sum : acc_q + sq_sum;

      min1_valid_d = min1_valid_q;
      min1_node_d  = min1_node_q;
      min1_dist_d  = min1_dist_q;
      min2_valid_d = min2_valid_q;
      min2_node_d  = min2_node_q;
      min2_dist_d  = min2_dist_q;
      if (accept) begin
         min1_valid_d = 1'b0;
         min1_node_d  = '0;
         min1_dist_d  = '0;
         min2_valid_d = 1'b0;
         min2_node_d  = '0;
         min2_dist_d  = '0;
      end else if (p2_valid_q && p2_last_q) begin
         // candidate is the completed node distance (acc_d), not acc_q
         if (!min1_valid_q || acc_d < min1_dist_q) begin
            min2_valid_d = min1_valid_q;
            min2_node_d  = min1_node_q;
            min2_dist_d  = min1_dist_q;
            min1_valid_d = 1'b1;
            min1_node_d  = p2_node_q;
            min1_dist_d  = acc_d;
         end else if (!min2_valid_q || acc_d < min2_dist_q) begin
            min2_valid_d = 1'b1;
            min2_node_d  = p2_node_q;
            min2_dist_d  = acc_d;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         x_q          <= '0;
         n_q          <= '0;
         node_q       <= '0;
         beat_q       <= '0;
         p1_valid_q   <= 1'b0;
         p1_first_q   <= 1'b0;
         p1_last_q    <= 1'b0;
         p1_node_q    <= '0;
         p1_beat_q    <= '0;
         p2_valid_q   <= 1'b0;
         p2_first_q   <= 1'b0;
         p2_last_q    <= 1'b0;
         p2_node_q    <= '0;
         for (int unsigned l = 0; l < LANES; l++) diff_q[l] <= '0;
         acc_q        <= '0;
         min1_valid_q <= 1'b0;
         min1_node_q  <= '0;
         min1_dist_q  <= '0;
         min2_valid_q <= 1'b0;
         min2_node_q  <= '0;
         min2_dist_q  <= '0;
      end else begin
         state_q      <= state_d;
         x_q          <= x_d;
         n_q          <= n_d;
         node_q       <= node_d;
         beat_q       <= beat_d;
         p1_valid_q   <= (state_q == S_ISSUE);
         p1_first_q   <= (beat_q == '0);
         p1_last_q    <= (beat_q == BEAT_LAST);
         p1_node_q    <= node_q;
         p1_beat_q    <= beat_q;
         p2_valid_q   <= p1_valid_q;
         p2_first_q   <= p1_first_q;
         p2_last_q    <= p1_last_q;
         p2_node_q    <= p1_node_q;
         for (int unsigned l = 0; l < LANES; l++) diff_q[l] <= diff_d[l];
         acc_q        <= acc_d;
         min1_valid_q <= min1_valid_d;
         min1_node_q  <= min1_node_d;
         min1_dist_q  <= min1_dist_d;
         min2_valid_q <= min2_valid_d;
         min2_node_q  <= min2_node_d;
         min2_dist_q  <= min2_dist_d;
      end
   end

   // ---------------- optional novelty flag ----------------
`ifdef GAM_WINNER_THRESH_EN
   logic [DIST_W-1:0] thr_q, thr_d;
   logic              novel_q, novel_d;

   always_comb begin
      thr_d   = thr_q;
      novel_d = novel_q;
      if (accept) begin
         thr_d   = bus.thresh;
         // an empty scan goes straight to DONE with no winner, hence novel
         novel_d = (bus.num_nodes == '0);
      end else if (state_q == S_DRAIN && final_update) begin
         // evaluated on the next-state minima so it is final together with them
         novel_d = !min1_valid_d || (min1_dist_d > thr_q);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         thr_q   <= '0;
         novel_q <= 1'b0;
      end else begin
         thr_q   <= thr_d;
         novel_q <= novel_d;
      end
   end

   assign bus.novel = novel_q;
`else
   logic unused_thresh;
   assign unused_thresh = ^bus.thresh;
   assign bus.novel     = 1'b0;
`endif

   // ---------------- outputs ----------------
   assign bus.rd_en      = (state_q == S_ISSUE);
   assign bus.rd_node    = node_q;
   assign bus.rd_beat    = beat_q;
   assign bus.busy       = (state_q != S_IDLE);
   assign bus.done       = (state_q == S_DONE);
   assign bus.min1_valid = min1_valid_q;
   assign bus.min1_node  = min1_node_q;
   assign bus.min1_dist  = min1_dist_q;
   assign bus.min2_valid = min2_valid_q;
   assign bus.min2_node  = min2_node_q;
   assign bus.min2_dist  = min2_dist_q;
endmodule

// File: tb/tb_gam_winner_search.sv
// tb_gam_winner_search -- directed, table-driven bench for gam_winner_search
// (DIM=4, LANES=2, WIDTH=8, MAX_NODES=8) with a 1-cycle-latency node memory.
module tb_gam_winner_search;
   logic clk;
   logic rst_n;

   gam_winner_search_if #(.DIM(4), .LANES(2), .WIDTH(8), .MAX_NODES(8)) bus ();

   gam_winner_search #(.DIM(4), .LANES(2), .WIDTH(8), .MAX_NODES(8)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // node memory model: rd_data valid the cycle after rd_en
   logic [31:0] mem [8];
   always @(posedge clk) begin
      if (bus.rd_en) bus.rd_data <= mem[bus.rd_node][bus.rd_beat*16 +: 16];
   end

   typedef struct packed {
      logic [255:0] mem;
      logic [31:0]  x;
      logic [3:0]   n;
      logic [19:0]  thr;
      logic         m1v;
      logic [2:0]   m1n;
      logic [19:0]  m1d;
      logic         m2v;
      logic [2:0]   m2n;
      logic [19:0]  m2d;
      logic         nov;
      logic [7:0]   dc;
   } vec_t;

   localparam int NV = 8;
   vec_t tv [NV];
   int checks   = 0;
   int failures = 0;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic logic [31:0] n4(input int a, input int b, input int c, input int d);
      logic [31:0] r;
      r = {d[7:0], c[7:0], b[7:0], a[7:0]};
      return r;
   endfunction

   function automatic vec_t mk(input logic [31:0] x, input int n, input int thr,
                               input bit m1v, input int m1n, input int m1d,
                               input bit m2v, input int m2n, input int m2d,
                               input bit nov, input int dc);
      vec_t v;
      v     = '0;
      v.x   = x;
      v.n   = n[3:0];
      v.thr = thr[19:0];
      v.m1v = m1v;
      v.m1n = m1n[2:0];
      v.m1d = m1d[19:0];
      v.m2v = m2v;
      v.m2n = m2n[2:0];
      v.m2d = m2d[19:0];
      v.nov = nov;
      v.dc  = dc[7:0];
      return v;
   endfunction

   task automatic run_scan(input int idx, input bit hold);
      vec_t v;
      string tag;
      int done_cyc, rd_cnt, busy_cnt, first_rd, last_rd, exp_nov;
      v   = tv[idx];
      tag = $sformatf("v%0d%s", idx, hold ? "h" : "");
      for (int i = 0; i < 8; i++) mem[i] = v.mem[i*32 +: 32];
`ifdef GAM_WINNER_THRESH_EN
      exp_nov = int'(v.nov);
`else
      exp_nov = 0;
`endif
      @(negedge clk);
      bus.x_vec     = v.x;
      bus.num_nodes = v.n;
      bus.thresh    = v.thr;
      bus.start     = 1'b1;
      @(posedge clk);  // end of cycle 0
      done_cyc = -1; rd_cnt = 0; busy_cnt = 0; first_rd = 0; last_rd = 0;
      for (int c = 1; c <= 60; c++) begin
         @(negedge clk);
         if (!hold) bus.start = 1'b0;
         if (bus.rd_en) begin
            rd_cnt++;
            if (first_rd == 0) first_rd = c;
            last_rd = c;
         end
         if (bus.busy) busy_cnt++;
         if (bus.done) begin
            done_cyc = c;
            break;
         end
      end
      bus.start = 1'b0;
      chk({tag, " done_cycle"}, done_cyc, int'(v.dc));
      chk({tag, " rd_count"}, rd_cnt, int'(v.n) * 2);
      chk({tag, " rd_first"}, first_rd, (v.n != 0) ? 1 : 0);
      chk({tag, " rd_last"}, last_rd, int'(v.n) * 2);
      chk({tag, " busy_cycles"}, busy_cnt, int'(v.dc));
      chk({tag, " min1_valid"}, int'(bus.min1_valid), int'(v.m1v));
      chk({tag, " min1_node"}, int'(bus.min1_node), int'(v.m1n));
      chk({tag, " min1_dist"}, int'(bus.min1_dist), int'(v.m1d));
      chk({tag, " min2_valid"}, int'(bus.min2_valid), int'(v.m2v));
      chk({tag, " min2_node"}, int'(bus.min2_node), int'(v.m2n));
      chk({tag, " min2_dist"}, int'(bus.min2_dist), int'(v.m2d));
      chk({tag, " novel"}, int'(bus.novel), exp_nov);
      @(negedge clk);
      chk({tag, " busy_after"}, int'(bus.busy), 0);
      chk({tag, " done_after"}, int'(bus.done), 0);
      chk({tag, " hold_min1_dist"}, int'(bus.min1_dist), int'(v.m1d));
      chk({tag, " hold_min2_dist"}, int'(bus.min2_dist), int'(v.m2d));
      chk({tag, " hold_novel"}, int'(bus.novel), exp_nov);
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, " busy"}, int'(bus.busy), 0);
      chk({tag, " done"}, int'(bus.done), 0);
      chk({tag, " rd_en"}, int'(bus.rd_en), 0);
      chk({tag, " rd_node"}, int'(bus.rd_node), 0);
      chk({tag, " rd_beat"}, int'(bus.rd_beat), 0);
      chk({tag, " min1_valid"}, int'(bus.min1_valid), 0);
      chk({tag, " min1_dist"}, int'(bus.min1_dist), 0);
      chk({tag, " min2_valid"}, int'(bus.min2_valid), 0);
      chk({tag, " min2_dist"}, int'(bus.min2_dist), 0);
      chk({tag, " novel"}, int'(bus.novel), 0);
   endtask

   initial begin
      logic [31:0] x1234;
      int done_seen;
      x1234 = n4(1, 2, 3, 4);

      // x, n, thr, m1v m1n m1d, m2v m2n m2d, nov, done cycle
      tv[0] = mk(x1234, 3, 0,      1, 0, 0,      1, 2, 1,   0, 9);   // basic
      tv[0].mem[0*32 +: 32] = n4(1, 2, 3, 4);
      tv[0].mem[1*32 +: 32] = n4(0, 0, 0, 0);
      tv[0].mem[2*32 +: 32] = n4(1, 2, 3, 5);
      tv[1] = mk(x1234, 2, 0,      1, 0, 1,      1, 1, 1,   1, 7);   // tie
      tv[1].mem[0*32 +: 32] = n4(1, 2, 3, 5);
      tv[1].mem[1*32 +: 32] = n4(1, 2, 3, 3);
      tv[2] = mk(x1234, 1, 0,      1, 0, 30,     0, 0, 0,   1, 5);   // N=1
      tv[3] = mk(x1234, 0, 0,      0, 0, 0,      0, 0, 0,   1, 1);   // N=0
      tv[4] = mk(n4(-128, -128, -128, -128), 1, 260100,
                                   1, 0, 260100, 0, 0, 0,   0, 5);   // signed extremes
      tv[4].mem[0*32 +: 32] = n4(127, 127, 127, 127);
      tv[5] = mk(x1234, 3, 0,      1, 0, 1,      1, 2, 1,   1, 9);   // basic, node0 changed
      tv[5].mem[0*32 +: 32] = n4(1, 2, 3, 5);
      tv[5].mem[1*32 +: 32] = n4(0, 0, 0, 0);
      tv[5].mem[2*32 +: 32] = n4(1, 2, 3, 5);
      tv[6] = mk(x1234, 8, 5,      1, 7, 0,      1, 6, 1,   0, 19);  // full memory, improving
      for (int i = 0; i < 8; i++) tv[6].mem[i*32 +: 32] = n4(1, 2, 3, 4 + 7 - i);
      tv[7] = mk(x1234, 2, 10,     1, 1, 16,     1, 0, 120, 1, 7);   // negative weights
      tv[7].mem[0*32 +: 32] = n4(-1, -2, -3, -4);
      tv[7].mem[1*32 +: 32] = n4(5, 2, 3, 4);

      rst_n         = 1'b0;
      bus.start     = 1'b0;
      bus.x_vec     = '0;
      bus.num_nodes = '0;
      bus.thresh    = '0;
      repeat (3) @(negedge clk);
      chk_all_zero("reset");
      rst_n = 1'b1;

      for (int k = 0; k < NV; k++) run_scan(k, 1'b0);

      // reset asserted at cycle 4 of the basic scan
      for (int i = 0; i < 8; i++) mem[i] = tv[0].mem[i*32 +: 32];
      @(negedge clk);
      bus.x_vec     = tv[0].x;
      bus.num_nodes = tv[0].n;
      bus.thresh    = tv[0].thr;
      bus.start     = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.start = 1'b0;
      repeat (3) @(negedge clk);  // now in cycle 4
      chk("midscan busy_before", int'(bus.busy), 1);
      chk("midscan rd_node_before", int'(bus.rd_node), 1);
      rst_n = 1'b0;
      #1;
      chk_all_zero("midscan_reset");
      done_seen = 0;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         if (bus.done || bus.busy) done_seen++;
      end
      chk("midscan no_done", done_seen, 0);
      rst_n = 1'b1;

      run_scan(0, 1'b0);  // scan after reset
      run_scan(0, 1'b1);  // start held high throughout
      run_scan(3, 1'b0);  // empty scan after a full one
      run_scan(1, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/gam_winner_search.md
# gam_winner_search

Parametrised winner-search engine for the GAM memory layer: on `start`, scans stored node weight vectors from an external node memory, computes squared Euclidean distance to a latched input vector, and reports the two nearest nodes with their distances. It succeeds the single-distance/two-min datapath: it adds lane-parallel distance accumulation, configurable vector/node dimensions, a start/busy/done handshake, and an optional novelty (threshold) flag. It sits between the layer controller and the node weight memory.

## Interface
- `DIM`, 4: vector elements per node; must be divisible by `LANES`.
- `LANES`, 2: elements fetched and processed per cycle. Beats per node: `B = DIM/LANES`.
- `WIDTH`, 8: element width, signed two's complement.
- `MAX_NODES`, 8: node memory capacity.
- Derived: `DIST_W = 2*WIDTH+2+$clog2(DIM)`; `NODE_W = $clog2(MAX_NODES)`; `CNT_W = $clog2(MAX_NODES+1)`; `BEAT_W = max(1,$clog2(B))`.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: begin a scan; sampled only in IDLE.
- `x_vec` in DIM*WIDTH: input vector, element 0 in the LSBs; latched on the accepted `start`.
- `num_nodes` in CNT_W: nodes to scan (0..MAX_NODES); latched on `start`.
- `thresh` in DIST_W: novelty threshold; latched on `start` (macro only).
- `rd_en` out 1: node memory read strobe.
- `rd_node` out NODE_W: node index.
- `rd_beat` out BEAT_W: lane group; elements `rd_beat*LANES .. +LANES-1`.
- `rd_data` in LANES*WIDTH: read data, valid exactly 1 cycle after `rd_en`.
- `busy` out 1: high from the cycle after `start` is accepted until `done`, inclusive.
- `done` out 1: one-cycle pulse when results are final.
- `min1_valid`, `min2_valid` out 1: winner and runner-up exist.
- `min1_node`, `min2_node` out NODE_W; `min1_dist`, `min2_dist` out DIST_W.
- `novel` out 1: `min1_dist > thresh` (macro only).

## Operation
- FSM: IDLE -> ISSUE -> DRAIN -> DONE -> IDLE.
- IDLE: `start`=1 latches `x_vec`, `num_nodes`, `thresh`, and clears the minima and valids. If `num_nodes==0`, go to DONE; otherwise go to ISSUE.
- ISSUE: one read per cycle, back to back, with `rd_beat` inner and `rd_node` outer, starting at node 0 / beat 0. After N*B reads, go to DRAIN.
- Datapath, pipelined:
  - Stage 1: for each lane, register `diff = rd_data_lane - x_lane`, sign-extended to WIDTH+1.
  - Stage 2: add the sum of lane squares to the accumulator; the first beat of a node loads rather than adds.
  - No overflow is possible at `DIST_W`.
- Two-min update on the final beat of each node, with candidate distance `d`:
  - If `!min1_valid` or `d < min1_dist`: min1 moves to min2, and `d` becomes min1.
  - Else if `!min2_valid` or `d < min2_dist`: `d` becomes min2.
  - Comparisons are strictly less-than, so on ties the lower node index wins.
- DRAIN: wait until the last node's update has completed, then go to DONE.
- DONE: pulse `done`, drop `busy` the next cycle, return to IDLE.
- Results hold until the next accepted `start`.
- `start` is ignored outside IDLE.
- `rd_en`=0 outside ISSUE; `rd_node`/`rd_beat` are 0 when idle.
- Reset values: all outputs 0; FSM in IDLE.
- Reset asserted mid-scan: outputs and FSM go to reset values immediately; no `done` is produced for the aborted scan.

## Timing
- Let cycle 0 be the cycle `start` is sampled in IDLE.
- N>0:
  - `rd_en` high in cycles 1..N*B.
  - `rd_data` valid in cycles 2..N*B+1.
  - `done` is asserted in cycle N*B+3 (DRAIN occupies cycle N*B+2).
  - `busy` is high in cycles 1..N*B+3.
- N=0: `done` and `busy` are high in cycle 1; both valids are 0.
- Result outputs are stable from the `done` cycle onward.
- Back-to-back scans: the earliest next `start` is the cycle after `done`.

## Configuration
- `GAM_WINNER_THRESH_EN` defined:
  - `thresh` is latched.
  - `novel` is registered in the cycle before `done`, equal to `!min1_valid || min1_dist > thresh`, and held with the results.
- Not defined:
  - `thresh` is unused.
  - `novel` is tied to 0.
  - No comparator logic is generated.

## Test plan
All cases use DIM=4, LANES=2, WIDTH=8, MAX_NODES=8, x=(1,2,3,4).
- Basic scan: nodes (1,2,3,4), (0,0,0,0), (1,2,3,5), N=3 -> `done` at cycle 9; min1 = node 0 / dist 0; min2 = node 2 / dist 1; `rd_en` high in cycles 1..6.
- Tie: nodes (1,2,3,5), (1,2,3,3), N=2 -> min1 = node 0 / dist 1; min2 = node 1 / dist 1.
- Boundary counts:
  - N=1 with node (0,0,0,0) -> min1 dist 30, `min2_valid`=0, `done` at cycle 5.
  - N=0 -> `done` at cycle 1, both valids 0, `rd_en` never high.
- Signed extremes: x all -128, node all 127, N=1 -> `min1_dist`=260100 with no wrap.
- Reset and control:
  - `rst_n` low at cycle 4 of a scan -> all outputs 0 immediately, no `done`.
  - A new scan after reset completes normally.
  - `start` held high during a scan is ignored.
- Macro defined, basic scan:
  - `thresh`=0 -> `novel`=0.
  - Same scan with node 0 changed to (1,2,3,5) and `thresh`=0 -> min1 dist 1, `novel`=1.
